// File: rtl/spw_inport_ctrl.sv
// SpaceWire input-port controller: pops characters from the port's FWFT receive
// FIFO, decodes the path-address header, requests an output column of the switch
// matrix, then streams the packet body (with its terminator) into the matrix cell.
// Bad headers, acknowledge timeouts and link errors cause the packet to be discarded
// or truncated with an injected EEP.
module spw_inport_ctrl #(
  parameter int DW        = 9,
  parameter int PORTNUM   = 16,
  parameter int AW        = 4,
  parameter int SELF_PORT = 0,
  parameter int ACK_TO    = 1023,
  parameter int TOW       = 10
) (
  input  logic          gclk,
  input  logic          reset,
  input  logic          rx_empty_i,
  input  logic [DW-1:0] rx_data_i,
  output logic          rx_rd_o,
  input  logic          link_err_i,
  output logic          sop_req_o,
  input  logic          sop_ack_i,
  output logic [AW-1:0] out_addr_o,
  input  logic          spc_i,
  output logic [DW-1:0] data_o,
  output logic          dv_o,
  output logic          eop_o,
  output logic          busy_o,
  output logic          hdr_err_o,
  output logic [7:0]    err_cnt_o
);

  typedef enum logic [2:0] {IDLE, REQ, FWD, INJ, DISC} state_t;

  localparam logic [DW-1:0] EEP_CHAR = DW'(9'h101);
  localparam logic [TOW-1:0] TO_LAST = TOW'(ACK_TO - 1);

  state_t        state_q, state_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic          sop_req_q, sop_req_d;
  logic          hdr_err_q, hdr_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic       is_ctrl;
  logic       is_term;
  logic [7:0] hdr;
  logic       hdr_valid;

  // Classify the FIFO head: control flag, terminator (EOP/EEP) and header validity.
  always_comb begin
    is_ctrl   = rx_data_i[DW-1];
    is_term   = rx_data_i[DW-1] && (rx_data_i[7:1] == 7'd0);
    hdr       = rx_data_i[7:0];
    hdr_valid = (32'(hdr) < PORTNUM) && (32'(hdr) != SELF_PORT);
  end

  // Next-state, FIFO pop and matrix-side strobes; strobes are held low during reset
  // so a reset cycle never pops the FIFO or writes the matrix cell.
  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    out_addr_d = out_addr_q;
    sop_req_d  = 1'b0;
    hdr_err_d  = 1'b0;
    rx_rd_o    = 1'b0;
    dv_o       = 1'b0;
    eop_o      = 1'b0;
    data_o     = '0;
    case (state_q)
      IDLE: begin
        if (!rx_empty_i) begin
          rx_rd_o = 1'b1;
          if (is_ctrl) begin
            hdr_err_d = 1'b1;
          end else begin
            out_addr_d = hdr[AW-1:0];
            if (hdr_valid) begin
              state_d   = REQ;
              sop_req_d = 1'b1;
              to_cnt_d  = '0;
            end else begin
              state_d   = DISC;
              hdr_err_d = 1'b1;
            end
          end
        end
      end
      REQ: begin
        if (sop_ack_i) begin
          state_d  = FWD;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = DISC;
          hdr_err_d = 1'b1;
          to_cnt_d  = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      FWD: begin
        if (!rx_empty_i && spc_i) begin
          rx_rd_o = 1'b1;
          dv_o    = 1'b1;
          data_o  = rx_data_i;
          if (is_term) begin
            eop_o   = 1'b1;
            state_d = IDLE;
          end
        end
        if (link_err_i && !(rx_rd_o && is_term)) begin
          state_d = INJ;
        end
      end
      INJ: begin
        if (spc_i) begin
          data_o  = EEP_CHAR;
          dv_o    = 1'b1;
          eop_o   = 1'b1;
          state_d = DISC;
        end
      end
      DISC: begin
        if (!rx_empty_i) begin
          rx_rd_o = 1'b1;
          if (is_term) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    err_cnt_d = (hdr_err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    if (reset) begin
      rx_rd_o = 1'b0;
      dv_o    = 1'b0;
      eop_o   = 1'b0;
      data_o  = '0;
    end
  end

  // State, timeout counter, held column address and registered error/request pulses.
  always_ff @(posedge gclk) begin
    if (reset) begin
      state_q    <= IDLE;
      to_cnt_q   <= '0;
      out_addr_q <= '0;
      sop_req_q  <= 1'b0;
      hdr_err_q  <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      out_addr_q <= out_addr_d;
      sop_req_q  <= sop_req_d;
      hdr_err_q  <= hdr_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign sop_req_o  = sop_req_q;
  assign hdr_err_o  = hdr_err_q;
  assign out_addr_o = out_addr_q;
  assign err_cnt_o  = err_cnt_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_spw_inport_ctrl.sv
// Bench for the SpaceWire input-port controller: a cycle-by-cycle vector table for
// header decode, forwarding, discard and link-error truncation, plus hand-written
// sequences for the acknowledge timeout, cell back-pressure and mid-packet reset.
module tb_spw_inport_ctrl;

  logic       gclk = 1'b0;
  logic       reset;
  logic       rx_empty_i;
  logic [8:0] rx_data_i;
  logic       rx_rd_o;
  logic       link_err_i;
  logic       sop_req_o;
  logic       sop_ack_i;
  logic [3:0] out_addr_o;
  logic       spc_i;
  logic [8:0] data_o;
  logic       dv_o;
  logic       eop_o;
  logic       busy_o;
  logic       hdr_err_o;
  logic [7:0] err_cnt_o;

  int checks = 0;
  int failures = 0;

  spw_inport_ctrl dut (
    .gclk(gclk), .reset(reset), .rx_empty_i(rx_empty_i), .rx_data_i(rx_data_i),
    .rx_rd_o(rx_rd_o), .link_err_i(link_err_i), .sop_req_o(sop_req_o),
    .sop_ack_i(sop_ack_i), .out_addr_o(out_addr_o), .spc_i(spc_i), .data_o(data_o),
    .dv_o(dv_o), .eop_o(eop_o), .busy_o(busy_o), .hdr_err_o(hdr_err_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 gclk = ~gclk;

  typedef struct {
    logic        empty;
    logic [8:0]  data;
    logic        lerr;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [8:0] fifo[$];

  logic       s_rd, s_dv, s_eop, s_sop, s_herr, s_busy;
  logic [8:0] s_data;
  logic [3:0] s_addr;
  logic [7:0] s_err;

  // Expected record: {rd,dv,eop,sop_req,hdr_err,busy, data_o (when dv), out_addr, err_cnt}
  function automatic vec_t mk(logic e, logic [8:0] d, logic l, logic [5:0] flags,
                              logic [8:0] dd, logic [3:0] a, logic [7:0] ec);
    vec_t r;
    r.empty = e;
    r.data  = d;
    r.lerr  = l;
    r.exp   = {flags, dd, a, ec};
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Capture every DUT output with inputs settled, one ns after the falling edge.
  task automatic sample_outputs();
    s_rd   = rx_rd_o;
    s_dv   = dv_o;
    s_eop  = eop_o;
    s_sop  = sop_req_o;
    s_herr = hdr_err_o;
    s_busy = busy_o;
    s_data = dv_o ? data_o : 9'h000;
    s_addr = out_addr_o;
    s_err  = err_cnt_o;
  endtask

  // Drive one table row for a full clock cycle and return the observed outputs.
  task automatic apply_stimulus(input vec_t r, output logic [26:0] act);
    @(negedge gclk);
    rx_empty_i = r.empty;
    rx_data_i  = r.data;
    link_err_i = r.lerr;
    #1;
    sample_outputs();
    act = {s_rd, s_dv, s_eop, s_sop, s_herr, s_busy, s_data, s_addr, s_err};
    @(posedge gclk);
  endtask

  // One cycle with the FIFO head taken from the modelled queue; pops when read.
  task automatic cycle();
    @(negedge gclk);
    rx_empty_i = (fifo.size() == 0);
    rx_data_i  = (fifo.size() == 0) ? 9'h000 : fifo[0];
    #1;
    sample_outputs();
    @(posedge gclk);
    if (s_rd && fifo.size() > 0) void'(fifo.pop_front());
  endtask

  initial begin
    logic [26:0] act;
    logic [8:0]  got[$];
    int req_cycles, sop_seen, dv_seen, bad, eops;
    logic herr_at_disc;

    reset = 1'b1; rx_empty_i = 1'b1; rx_data_i = '0; link_err_i = 1'b0;
    sop_ack_i = 1'b1; spc_i = 1'b1;
    repeat (3) @(posedge gclk);
    #1 reset = 1'b0;

    // Basic packet to column 5, self-port header, link error truncation,
    // stray terminator, out-of-range header, terminator beating a link error.
    vecs.push_back(mk(1, 9'h000, 0, 6'b000000, 9'h000, 4'd0, 8'd0));
    vecs.push_back(mk(0, 9'h005, 0, 6'b100000, 9'h000, 4'd0, 8'd0));
    vecs.push_back(mk(0, 9'h0AA, 0, 6'b000101, 9'h000, 4'd5, 8'd0));
    vecs.push_back(mk(0, 9'h0AA, 0, 6'b110001, 9'h0AA, 4'd5, 8'd0));
    vecs.push_back(mk(0, 9'h0BB, 0, 6'b110001, 9'h0BB, 4'd5, 8'd0));
    vecs.push_back(mk(0, 9'h100, 0, 6'b111001, 9'h100, 4'd5, 8'd0));
    vecs.push_back(mk(1, 9'h000, 0, 6'b000000, 9'h000, 4'd5, 8'd0));
    vecs.push_back(mk(0, 9'h000, 0, 6'b100000, 9'h000, 4'd5, 8'd0));
    vecs.push_back(mk(0, 9'h011, 0, 6'b100011, 9'h000, 4'd0, 8'd1));
    vecs.push_back(mk(0, 9'h100, 0, 6'b100001, 9'h000, 4'd0, 8'd1));
    vecs.push_back(mk(1, 9'h000, 0, 6'b000000, 9'h000, 4'd0, 8'd1));
    vecs.push_back(mk(0, 9'h004, 0, 6'b100000, 9'h000, 4'd0, 8'd1));
    vecs.push_back(mk(0, 9'h0D1, 0, 6'b000101, 9'h000, 4'd4, 8'd1));
    vecs.push_back(mk(0, 9'h0D1, 0, 6'b110001, 9'h0D1, 4'd4, 8'd1));
    vecs.push_back(mk(0, 9'h0D2, 1, 6'b110001, 9'h0D2, 4'd4, 8'd1));
    vecs.push_back(mk(0, 9'h0D3, 0, 6'b011001, 9'h101, 4'd4, 8'd1));
    vecs.push_back(mk(0, 9'h0D3, 0, 6'b100001, 9'h000, 4'd4, 8'd1));
    vecs.push_back(mk(0, 9'h0D4, 0, 6'b100001, 9'h000, 4'd4, 8'd1));
    vecs.push_back(mk(0, 9'h0D5, 0, 6'b100001, 9'h000, 4'd4, 8'd1));
    vecs.push_back(mk(0, 9'h0D6, 0, 6'b100001, 9'h000, 4'd4, 8'd1));
    vecs.push_back(mk(0, 9'h100, 0, 6'b100001, 9'h000, 4'd4, 8'd1));
    vecs.push_back(mk(1, 9'h000, 0, 6'b000000, 9'h000, 4'd4, 8'd1));
    vecs.push_back(mk(0, 9'h101, 0, 6'b100000, 9'h000, 4'd4, 8'd1));
    vecs.push_back(mk(1, 9'h000, 0, 6'b000010, 9'h000, 4'd4, 8'd2));
    vecs.push_back(mk(0, 9'h020, 0, 6'b100000, 9'h000, 4'd4, 8'd2));
    vecs.push_back(mk(0, 9'h100, 0, 6'b100011, 9'h000, 4'd0, 8'd3));
    vecs.push_back(mk(1, 9'h000, 0, 6'b000000, 9'h000, 4'd0, 8'd3));
    vecs.push_back(mk(0, 9'h007, 0, 6'b100000, 9'h000, 4'd0, 8'd3));
    vecs.push_back(mk(0, 9'h0E0, 0, 6'b000101, 9'h000, 4'd7, 8'd3));
    vecs.push_back(mk(0, 9'h0E0, 0, 6'b110001, 9'h0E0, 4'd7, 8'd3));
    vecs.push_back(mk(0, 9'h101, 1, 6'b111001, 9'h101, 4'd7, 8'd3));
    vecs.push_back(mk(1, 9'h000, 0, 6'b000000, 9'h000, 4'd7, 8'd3));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i], act);
      check_output($sformatf("vec[%0d]", i), 32'(act), 32'(vecs[i].exp));
    end
    link_err_i = 1'b0;

    // Acknowledge timeout: header 3, ack held low, body discarded afterwards.
    sop_ack_i = 1'b0;
    fifo = '{9'h003, 9'h011, 9'h100};
    cycle();
    req_cycles = 0; sop_seen = 0; dv_seen = 0; herr_at_disc = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      cycle();
      if (s_sop) sop_seen++;
      if (s_dv) dv_seen++;
      if (s_rd) begin
        herr_at_disc = s_herr;
        break;
      end
      req_cycles++;
    end
    check_output("timeout_req_cycles", 32'(req_cycles), 32'd1023);
    check_output("timeout_sop_pulses", 32'(sop_seen), 32'd1);
    check_output("timeout_hdr_err", 32'(herr_at_disc), 32'd1);
    cycle();
    if (s_dv) dv_seen++;
    cycle();
    check_output("timeout_no_dv", 32'(dv_seen), 32'd0);
    check_output("timeout_idle_busy", 32'(s_busy), 32'd0);
    check_output("timeout_err_cnt", 32'(s_err), 32'd4);
    sop_ack_i = 1'b1;

    // Cell back-pressure for 10 cycles in the middle of the body.
    fifo = '{9'h006, 9'h0A1, 9'h0A2, 9'h0A3, 9'h100};
    cycle();
    cycle();
    cycle();
    check_output("stall_first_byte", 32'(s_data), 32'h0A1);
    spc_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_rd || s_dv) bad++;
    end
    check_output("stall_no_activity", 32'(bad), 32'd0);
    spc_i = 1'b1;
    got.delete();
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_dv) got.push_back(s_data);
      if (s_eop) break;
    end
    check_output("stall_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      check_output("stall_byte2", 32'(got[0]), 32'h0A2);
      check_output("stall_byte3", 32'(got[1]), 32'h0A3);
      check_output("stall_eop", 32'(got[2]), 32'h100);
    end
    check_output("stall_addr", 32'(s_addr), 32'd6);

    // Reset in the middle of forwarding, then a fresh packet to column 2.
    fifo = '{9'h009, 9'h055, 9'h066, 9'h100};
    cycle();
    cycle();
    cycle();
    check_output("rst_pre_fwd", 32'(s_data), 32'h055);
    reset = 1'b1;
    fifo.delete();
    cycle();
    check_output("rst_no_eop_in_reset", 32'({s_dv, s_eop, s_rd}), 32'd0);
    reset = 1'b0;
    cycle();
    check_output("rst_outputs", 32'({s_rd, s_dv, s_eop, s_sop, s_herr, s_busy, s_data, s_addr, s_err}), 32'd0);
    fifo = '{9'h002, 9'h077, 9'h100};
    got.delete();
    eops = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_dv) got.push_back(s_data);
      if (s_eop) eops++;
    end
    check_output("post_rst_addr", 32'(s_addr), 32'd2);
    check_output("post_rst_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check_output("post_rst_byte", 32'(got[0]), 32'h077);
      check_output("post_rst_eop", 32'(got[1]), 32'h100);
    end
    check_output("post_rst_eop_pulses", 32'(eops), 32'd1);
    check_output("post_rst_idle", 32'(s_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
